// File: rtl/mig_ddr3_traffic_gen_if.sv
// Request/response bus between the DDR3 traffic generator and the memory port.
// The generator drives requests and consumes in-order read responses.
interface mig_ddr3_traffic_gen_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 128
);
  logic                    req_v_o;
  logic                    req_ready_i;
  logic                    req_w_o;
  logic [addr_width_p-1:0] req_addr_o;
  logic [data_width_p-1:0] req_data_o;
  logic                    resp_v_i;
  logic [data_width_p-1:0] resp_data_i;

  modport master (
    output req_v_o, req_w_o, req_addr_o, req_data_o,
    input  req_ready_i, resp_v_i, resp_data_i
  );

  modport slave (
    input  req_v_o, req_w_o, req_addr_o, req_data_o,
    output req_ready_i, resp_v_i, resp_data_i
  );
endinterface

// File: rtl/mig_ddr3_traffic_gen.sv
// Memory traffic generator: writes words_p patterned words, reads them back with
// bounded reads in flight, and reports mismatch count and first failing address.
module mig_ddr3_traffic_gen #(
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 128,
  parameter int words_p           = 256,
  parameter int max_outstanding_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_active_low_i,
  input  logic                    start_i,
  input  logic [1:0]              mode_i,
  input  logic [addr_width_p-1:0] base_addr_i,
  mig_ddr3_traffic_gen_if.master  bus,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [15:0]             error_count_o,
  output logic [addr_width_p-1:0] first_err_addr_o
);

  localparam int idx_w = $clog2(words_p);
  localparam int out_w = $clog2(max_outstanding_p + 1);
  localparam logic [addr_width_p-1:0] step_c     = addr_width_p'(data_width_p / 8);
  localparam logic [idx_w-1:0]        last_idx_c = idx_w'(words_p - 1);
  localparam logic [out_w-1:0]        max_out_c  = out_w'(max_outstanding_p);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_t;

  state_t                  state;
  logic [1:0]              mode_q;
  logic [addr_width_p-1:0] base_q;
  logic [idx_w-1:0]        idx;
  logic [idx_w-1:0]        exp_idx;
  logic [out_w-1:0]        outstanding;

  logic                    req_fire;
  logic                    rd_fire;
  logic                    resp_ok;
  logic                    resp_stray;
  logic                    mismatch;
  logic                    accept;
  logic [out_w-1:0]        out_next;
  logic [15:0]             err_next;
  logic [addr_width_p-1:0] first_err_next;

  function automatic logic [addr_width_p-1:0] word_addr(
    input logic [addr_width_p-1:0] base,
    input logic [idx_w-1:0]        i
  );
    return base + addr_width_p'(i) * step_c;
  endfunction

  function automatic logic [data_width_p-1:0] pattern(
    input logic [1:0]              mode,
    input logic [addr_width_p-1:0] base,
    input logic [idx_w-1:0]        i
  );
    logic [data_width_p-1:0] addr_ext;
    addr_ext = data_width_p'(word_addr(base, i));
    case (mode)
      2'd0:    return addr_ext;
      2'd1:    return ~addr_ext;
      2'd2:    return data_width_p'(1) << (32'(i) % data_width_p);
      default: return i[0] ? '0 : '1;
    endcase
  endfunction

  // A response with nothing in flight is an error on its own and never advances the compare index.
  always_comb begin
    req_fire       = bus.req_v_o && bus.req_ready_i;
    rd_fire        = req_fire && (state == READ);
    resp_ok        = bus.resp_v_i && (outstanding != '0);
    resp_stray     = bus.resp_v_i && (outstanding == '0);
    mismatch       = resp_ok && (bus.resp_data_i != pattern(mode_q, base_q, exp_idx));
    accept         = start_i && ((state == IDLE) || (state == DONE));
    out_next       = outstanding;
    if (rd_fire && !resp_ok) begin
      out_next = outstanding + out_w'(1);
    end else if (!rd_fire && resp_ok) begin
      out_next = outstanding - out_w'(1);
    end
    err_next = error_count_o;
    if ((mismatch || resp_stray) && (error_count_o != 16'hFFFF)) begin
      err_next = error_count_o + 16'd1;
    end
    first_err_next = first_err_addr_o;
    if (mismatch && (error_count_o == '0)) begin
      first_err_next = word_addr(base_q, exp_idx);
    end
  end

  always_ff @(posedge clk_i or negedge reset_active_low_i) begin
    if (!reset_active_low_i) begin
      state            <= IDLE;
      mode_q           <= '0;
      base_q           <= '0;
      idx              <= '0;
      exp_idx          <= '0;
      outstanding      <= '0;
      error_count_o    <= '0;
      first_err_addr_o <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      bus.req_v_o      <= 1'b0;
      bus.req_w_o      <= 1'b0;
      bus.req_addr_o   <= '0;
      bus.req_data_o   <= '0;
    end else begin
      outstanding      <= out_next;
      error_count_o    <= err_next;
      first_err_addr_o <= first_err_next;
      if (resp_ok) begin
        exp_idx <= exp_idx + idx_w'(1);
      end
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state            <= WRITE;
            mode_q           <= mode_i;
            base_q           <= base_addr_i;
            idx              <= '0;
            exp_idx          <= '0;
            outstanding      <= '0;
            error_count_o    <= '0;
            first_err_addr_o <= '0;
            busy_o           <= 1'b1;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            bus.req_v_o      <= 1'b1;
            bus.req_w_o      <= 1'b1;
            bus.req_addr_o   <= base_addr_i;
            bus.req_data_o   <= pattern(mode_i, base_addr_i, '0);
          end
        end
        WRITE: begin
          if (req_fire) begin
            if (idx == last_idx_c) begin
              state          <= READ;
              idx            <= '0;
              bus.req_w_o    <= 1'b0;
              bus.req_addr_o <= base_q;
              bus.req_data_o <= pattern(mode_q, base_q, '0);
              bus.req_v_o    <= (out_next < max_out_c);
            end else begin
              idx            <= idx + idx_w'(1);
              bus.req_addr_o <= bus.req_addr_o + step_c;
              bus.req_data_o <= pattern(mode_q, base_q, idx + idx_w'(1));
            end
          end
        end
        // Read valid is recomputed every cycle from the post-update count, so a
        // stalled request never drops while the window stays open.
        READ: begin
          if (rd_fire && (idx == last_idx_c)) begin
            state       <= WAIT;
            idx         <= '0;
            bus.req_v_o <= 1'b0;
          end else begin
            if (rd_fire) begin
              idx            <= idx + idx_w'(1);
              bus.req_addr_o <= bus.req_addr_o + step_c;
              bus.req_data_o <= pattern(mode_q, base_q, idx + idx_w'(1));
            end
            bus.req_v_o <= (out_next < max_out_c);
          end
        end
        WAIT: begin
          if (out_next == '0) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (err_next == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_ddr3_traffic_gen.sv
// Bench for mig_ddr3_traffic_gen: a behavioural memory with configurable stall,
// latency and bit corruption, checked against pattern rules computed directly.
module tb_mig_ddr3_traffic_gen;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int WORDS = 8;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] base = '0;
  logic          busy, done, pass;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err;

  mig_ddr3_traffic_gen_if #(.addr_width_p(AW), .data_width_p(DW)) bus ();

  mig_ddr3_traffic_gen #(
    .addr_width_p(AW), .data_width_p(DW), .words_p(WORDS), .max_outstanding_p(MAXO)
  ) dut (
    .clk_i(clk), .reset_active_low_i(rst_n), .start_i(start), .mode_i(mode),
    .base_addr_i(base), .bus(bus), .busy_o(busy), .done_o(done), .pass_o(pass),
    .error_count_o(err_cnt), .first_err_addr_o(first_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_pct = 100, resp_delay = 1, flip_idx = -1;
  bit mem_en = 1'b0;
  int cyc = 0, out_model = 0, max_out_seen = 0, stab_viol = 0, block_viol = 0, rd_count = 0;
  bit pend_rd = 1'b0, pend_resp = 1'b0, prev_stall = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  logic          held_w;
  logic [AW-1:0] wr_addr_q[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  typedef struct { int due; logic [DW-1:0] data; } resp_t;
  resp_t resp_q[$];

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] b, input int i);
    return b + AW'(i * (DW / 8));
  endfunction

  function automatic logic [DW-1:0] model_data(input int m, input logic [AW-1:0] b, input int i);
    logic [DW-1:0] a;
    a = DW'(model_addr(b, i));
    case (m)
      0: return a;
      1: return ~a;
      2: return DW'(1) << (i % DW);
      default: return (i % 2 == 0) ? {DW{1'b1}} : {DW{1'b0}};
    endcase
  endfunction

  // Number of logged requests that deviate from the expected write/read sequence.
  function automatic int log_mismatches(input int m, input logic [AW-1:0] b);
    int n = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (i >= wr_addr_q.size() || wr_addr_q[i] !== model_addr(b, i) || wr_data_q[i] !== model_data(m, b, i)) n++;
      if (i >= rd_addr_q.size() || rd_addr_q[i] !== model_addr(b, i)) n++;
    end
    if (wr_addr_q.size() > WORDS) n++;
    if (rd_addr_q.size() > WORDS) n++;
    return n;
  endfunction

  // Memory model and bus monitor: drives inputs on the falling edge, predicts the
  // handshakes the next rising edge will complete and tracks reads in flight.
  initial begin
    logic [DW-1:0] d;
    bus.req_ready_i = 1'b0;
    bus.resp_v_i    = 1'b0;
    bus.resp_data_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        resp_q.delete();
        out_model = 0;
      end
      if (!rst_n || !mem_en) begin
        pend_rd = 1'b0; pend_resp = 1'b0; prev_stall = 1'b0;
        if (mem_en) begin
          bus.req_ready_i = 1'b0;
          bus.resp_v_i    = 1'b0;
        end
      end else begin
        if (pend_rd) out_model++;
        if (pend_resp && out_model > 0) out_model--;
        if (out_model > max_out_seen) max_out_seen = out_model;
        if (bus.req_v_o === 1'b1 && bus.req_w_o === 1'b0 && out_model >= MAXO) block_viol++;
        if (prev_stall && (bus.req_v_o !== 1'b1 || bus.req_addr_o !== held_addr ||
                           bus.req_data_o !== held_data || bus.req_w_o !== held_w)) stab_viol++;
        bus.req_ready_i = ($urandom_range(99) < ready_pct);
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
          bus.resp_v_i    = 1'b1;
          bus.resp_data_i = resp_q[0].data;
          void'(resp_q.pop_front());
        end else begin
          bus.resp_v_i = 1'b0;
        end
        pend_resp = bus.resp_v_i;
        pend_rd   = 1'b0;
        if (bus.req_v_o === 1'b1 && bus.req_ready_i) begin
          if (bus.req_w_o) begin
            wr_addr_q.push_back(bus.req_addr_o);
            wr_data_q.push_back(bus.req_data_o);
            mem_arr[bus.req_addr_o] = bus.req_data_o;
          end else begin
            d = mem_arr.exists(bus.req_addr_o) ? mem_arr[bus.req_addr_o] : '0;
            if (rd_count == flip_idx) d[0] = ~d[0];
            resp_q.push_back('{cyc + resp_delay, d});
            rd_addr_q.push_back(bus.req_addr_o);
            rd_count++;
            pend_rd = 1'b1;
          end
        end
        prev_stall = (bus.req_v_o === 1'b1) && !bus.req_ready_i;
        held_addr  = bus.req_addr_o;
        held_data  = bus.req_data_o;
        held_w     = bus.req_w_o;
      end
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); mem_arr.delete();
    rd_count = 0; max_out_seen = 0; stab_viol = 0; block_viol = 0;
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [AW-1:0] b);
    @(negedge clk);
    start = 1'b1; mode = m; base = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: busy/done/pass=%b%b%b expected 000", busy, done, pass);
    end
    checks++;
    if (err_cnt !== 16'd0 || first_err !== '0) begin
      errors++; $display("[TB] FAIL reset_counters: err=%0d first=%h expected 0/0", err_cnt, first_err);
    end
    checks++;
    if (bus.req_v_o !== 1'b0 || bus.req_w_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req: v=%b w=%b expected 0/0", bus.req_v_o, bus.req_w_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.req_v_o !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_without_start: busy=%b v=%b expected 0/0", busy, bus.req_v_o);
    end
  endtask

  task automatic test_basic();
    bit to;
    mem_en = 1'b1; ready_pct = 100; resp_delay = 1; flip_idx = -1;
    clear_logs();
    pulse_start(2'd0, 28'h100);
    checks++;
    if (bus.req_v_o !== 1'b1 || bus.req_w_o !== 1'b1 || busy !== 1'b1 || bus.req_addr_o !== 28'h100) begin
      errors++; $display("[TB] FAIL basic_first_write: v=%b w=%b busy=%b addr=%h expected 1/1/1/100",
                         bus.req_v_o, bus.req_w_o, busy, bus.req_addr_o);
    end
    wait_done(to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL basic_timeout: done never rose"); end
    checks++;
    if (log_mismatches(0, 28'h100) !== 0) begin
      errors++; $display("[TB] FAIL basic_sequence: %0d bad requests expected 0", log_mismatches(0, 28'h100));
    end
    checks++;
    if (wr_addr_q.size() != WORDS || wr_addr_q[WORDS-1] !== 28'h170) begin
      errors++; $display("[TB] FAIL basic_last_addr: %0d writes expected %0d ending at 170", wr_addr_q.size(), WORDS);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_result: done=%b pass=%b err=%0d busy=%b expected 1/1/0/0",
                         done, pass, err_cnt, busy);
    end
  endtask

  task automatic test_bit_flip();
    bit to;
    ready_pct = 100; resp_delay = 1; flip_idx = 3;
    clear_logs();
    pulse_start(2'd2, 28'h200);
    wait_done(to);
    flip_idx = -1;
    checks++;
    if (to) begin errors++; $display("[TB] FAIL flip_timeout: done never rose"); end
    checks++;
    if (err_cnt !== 16'd1 || first_err !== 28'h230 || pass !== 1'b0) begin
      errors++; $display("[TB] FAIL flip_result: err=%0d first=%h pass=%b expected 1/230/0", err_cnt, first_err, pass);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    ready_pct = 100; resp_delay = 10; flip_idx = -1;
    clear_logs();
    pulse_start(2'd3, 28'h4000);
    wait_done(to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL b2b_timeout: done never rose"); end
    checks++;
    if (max_out_seen != MAXO || block_viol != 0) begin
      errors++; $display("[TB] FAIL b2b_window: max=%0d blocked_violations=%0d expected %0d/0", max_out_seen, block_viol, MAXO);
    end
    checks++;
    if (pass !== 1'b1 || log_mismatches(3, 28'h4000) !== 0) begin
      errors++; $display("[TB] FAIL b2b_result: pass=%b bad=%0d expected 1/0", pass, log_mismatches(3, 28'h4000));
    end
  endtask

  task automatic test_stall_random();
    bit to;
    int m;
    logic [AW-1:0] b;
    m = int'($urandom_range(3));
    b = AW'($urandom);
    ready_pct = 30; resp_delay = 10; flip_idx = -1;
    clear_logs();
    pulse_start(m[1:0], b);
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy: busy=%b expected 1", busy); end
    pulse_start(2'(m + 1), ~b);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_restart_ignored: busy=%b done=%b expected 1/0", busy, done);
    end
    wait_done(to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL stall_timeout: done never rose"); end
    checks++;
    if (stab_viol != 0 || block_viol != 0 || max_out_seen > MAXO) begin
      errors++; $display("[TB] FAIL stall_protocol: unstable=%0d blocked=%0d max=%0d expected 0/0/<=%0d",
                         stab_viol, block_viol, max_out_seen, MAXO);
    end
    checks++;
    if (pass !== 1'b1 || err_cnt !== 16'd0 || log_mismatches(m, b) !== 0) begin
      errors++; $display("[TB] FAIL stall_result: pass=%b err=%0d bad=%0d expected 1/0/0", pass, err_cnt, log_mismatches(m, b));
    end
  endtask

  task automatic test_wrap();
    bit to;
    ready_pct = 100; resp_delay = 1; flip_idx = -1;
    clear_logs();
    pulse_start(2'd0, 28'hFFFFFC0);
    wait_done(to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL wrap_timeout: done never rose"); end
    checks++;
    if (rd_addr_q.size() != WORDS || rd_addr_q[3] !== 28'hFFFFFF0 || rd_addr_q[4] !== 28'h0000000) begin
      errors++; $display("[TB] FAIL wrap_addr: %0d reads expected %0d wrapping FFFFFF0 -> 0000000", rd_addr_q.size(), WORDS);
    end
    checks++;
    if (pass !== 1'b1 || log_mismatches(0, 28'hFFFFFC0) !== 0) begin
      errors++; $display("[TB] FAIL wrap_result: pass=%b bad=%0d expected 1/0", pass, log_mismatches(0, 28'hFFFFFC0));
    end
  endtask

  task automatic test_random_runs();
    bit to;
    int m, f, exp_err;
    logic [AW-1:0] b, exp_first;
    for (int r = 0; r < 4; r++) begin
      m = int'($urandom_range(3));
      b = AW'($urandom);
      f = int'($urandom_range(9));
      ready_pct  = int'($urandom_range(100, 20));
      resp_delay = int'($urandom_range(12, 1));
      flip_idx   = (f < WORDS) ? f : -1;
      exp_err    = (f < WORDS) ? 1 : 0;
      exp_first  = (f < WORDS) ? model_addr(b, f) : '0;
      clear_logs();
      pulse_start(m[1:0], b);
      wait_done(to);
      checks++;
      if (to) begin errors++; $display("[TB] FAIL rand%0d_timeout: done never rose", r); end
      checks++;
      if (log_mismatches(m, b) !== 0 || stab_viol != 0 || max_out_seen > MAXO) begin
        errors++; $display("[TB] FAIL rand%0d_bus: bad=%0d unstable=%0d max=%0d expected 0/0/<=%0d",
                           r, log_mismatches(m, b), stab_viol, max_out_seen, MAXO);
      end
      checks++;
      if (err_cnt !== 16'(exp_err) || first_err !== exp_first || pass !== (exp_err == 0)) begin
        errors++; $display("[TB] FAIL rand%0d_result: err=%0d first=%h pass=%b expected %0d/%h/%b",
                           r, err_cnt, first_err, pass, exp_err, exp_first, exp_err == 0);
      end
    end
    flip_idx = -1;
  endtask

  task automatic test_reset_mid_run();
    bit to;
    logic [AW-1:0] b;
    b = AW'($urandom);
    ready_pct = 100; resp_delay = 10; flip_idx = -1;
    clear_logs();
    pulse_start(2'd1, b);
    for (int k = 0; k < 500 && rd_addr_q.size() < 3; k++) @(negedge clk);
    checks++;
    if (rd_addr_q.size() < 3) begin errors++; $display("[TB] FAIL midrun_reach_read: %0d reads expected >=3", rd_addr_q.size()); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || bus.req_v_o !== 1'b0 || err_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL midrun_reset: busy=%b done=%b pass=%b v=%b err=%0d expected all 0",
                         busy, done, pass, bus.req_v_o, err_cnt);
    end
    mem_en = 1'b0;
    bus.resp_v_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.resp_v_i    = 1'b1;
    bus.resp_data_i = {4{$urandom}};
    @(negedge clk);
    bus.resp_v_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL stray_response: err=%0d busy=%b expected 1/0", err_cnt, busy);
    end
    mem_en = 1'b1;
    clear_logs();
    b = AW'($urandom);
    pulse_start(2'd3, b);
    checks++;
    if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL restart_clears: err=%0d expected 0", err_cnt); end
    wait_done(to);
    checks++;
    if (to || pass !== 1'b1 || log_mismatches(3, b) !== 0) begin
      errors++; $display("[TB] FAIL fresh_run: timeout=%b pass=%b bad=%0d expected 0/1/0", to, pass, log_mismatches(3, b));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_bit_flip();
    test_back_to_back();
    test_stall_random();
    test_wrap();
    test_random_runs();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
